bus_reader: RTL

Receive-side partner of the tri-state counter bus driver. Owns the driver's output-enable (`oe`). On each request it:
- enables the bus and waits a settle time;
- samples the bus;
- releases the bus with a turnaround cycle;
- buffers the sample, plus its difference from the previous stored sample, in a small show-ahead FIFO with a valid/ready output.

It sits between the shared 8-bit bus and the game/sequence logic that consumes counter values.

---
 rtl/bus_reader.sv | 112 +++++++++++
 1 files changed

// File: rtl/bus_reader.sv
// Receive side of the tri-state counter bus: enables the driver, waits a settle
// time, captures the bus, releases it, and queues {sample, delta} in a show-ahead FIFO.
module bus_reader #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic [WIDTH-1:0]           bus,
  output logic                       oe,
  output logic                       busy,
  output logic [WIDTH-1:0]           out_data,
  output logic [WIDTH-1:0]           out_delta,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(SETTLE+1);

  // Handshake: an entry leaves the FIFO on any edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   settle_cnt, settle_nxt;

  logic [WIDTH-1:0] mem_data  [DEPTH];
  logic [WIDTH-1:0] mem_delta [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] prev;
  logic             full, capture, push, drop, pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      oe         <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      oe         <= (state_nxt == DRIVE) || (state_nxt == CAPTURE);
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt  = DRIVE;
          settle_nxt = SW'(SETTLE - 1);
        end
      end
      DRIVE: begin
        if (settle_cnt == '0) state_nxt = CAPTURE;
        else                  settle_nxt = settle_cnt - SW'(1);
      end
      CAPTURE: state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Fullness is judged before any same-edge pop, so a pop never makes room
  // for the sample being captured on that edge.
  assign full      = (count == CW'(DEPTH));
  assign capture   = (state == CAPTURE);
  assign push      = capture && !full;
  assign drop      = capture && full;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_data[rd_ptr];
  assign out_delta = mem_delta[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= bus;
      mem_delta[wr_ptr] <= bus - prev;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      prev     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        prev   <= bus;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
